// File: rtl/events_to_apb_arb.sv
// Per-channel saturating event counters reported round-robin as APB writes.
// Optional macro EVENTS_TO_APB_PSLVERR_EN: on pslverr, the reported count is restored to its channel.
module events_to_apb_arb #(
    parameter int unsigned          NUM_EVENTS  = 3,
    parameter int unsigned          CNT_W       = 16,
    parameter int unsigned          ADDR_W      = 32,
    parameter int unsigned          DATA_W      = 32,
    parameter logic [ADDR_W-1:0]    ADDR_BASE   = 32'hABBA_0000,
    parameter logic [ADDR_W-1:0]    ADDR_STRIDE = 32'h0001_0000
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_EVENTS-1:0]   event_i,
    output logic                    apb_psel_o,
    output logic                    apb_penable_o,
    output logic [ADDR_W-1:0]       apb_paddr_o,
    output logic                    apb_pwrite_o,
    output logic [DATA_W-1:0]       apb_pwdata_o,
    input  logic                    apb_pready_i,
    input  logic                    apb_pslverr_i
);

    localparam int unsigned GW = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt [NUM_EVENTS];
    logic [GW-1:0]      r_last_grant;
    logic               r_psel;
    logic               r_penable;
    logic               r_pwrite;
    logic [ADDR_W-1:0]  r_paddr;
    logic [DATA_W-1:0]  r_pwdata;

    logic               w_any;
    logic [GW-1:0]      w_grant;

    // First pending channel strictly after the previous winner, wrapping.
    always_comb begin
        int unsigned base;
        logic [GW-1:0] idx;
        w_any   = 1'b0;
        w_grant = '0;
        base    = 32'(r_last_grant);
        for (int unsigned i = 1; i <= NUM_EVENTS; i++) begin
            idx = GW'((base + i) % NUM_EVENTS);
            if (!w_any && (r_cnt[idx] != '0)) begin
                w_any   = 1'b1;
                w_grant = idx;
            end
        end
    end

`ifdef EVENTS_TO_APB_PSLVERR_EN
    localparam int unsigned SW = CNT_W + 2;
    logic [SW-1:0]      w_restore_sum;
    logic [CNT_W-1:0]   w_restore;

    // Rejected count goes back on top of whatever accumulated meanwhile.
    always_comb begin
        w_restore_sum = SW'(r_cnt[r_last_grant]) + SW'(apb_pwdata_o[CNT_W-1:0])
                      + SW'(event_i[r_last_grant]);
        w_restore     = (w_restore_sum > SW'(CNT_MAX)) ? CNT_MAX : w_restore_sum[CNT_W-1:0];
    end
`else
    logic w_unused_pslverr;
    assign w_unused_pslverr = apb_pslverr_i;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned ch = 0; ch < NUM_EVENTS; ch++) begin
                r_cnt[ch] <= '0;
            end
        end else begin
            for (int unsigned ch = 0; ch < NUM_EVENTS; ch++) begin
                if ((r_state == S_IDLE) && w_any && (w_grant == GW'(ch))) begin
                    r_cnt[ch] <= CNT_W'(event_i[ch]);
`ifdef EVENTS_TO_APB_PSLVERR_EN
                end else if ((r_state == S_ACCESS) && apb_pready_i && apb_pslverr_i
                             && (r_last_grant == GW'(ch))) begin
                    r_cnt[ch] <= w_restore;
`endif
                end else if (event_i[ch] && (r_cnt[ch] != CNT_MAX)) begin
                    r_cnt[ch] <= r_cnt[ch] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_last_grant <= GW'(NUM_EVENTS - 1);
            r_psel       <= 1'b0;
            r_penable    <= 1'b0;
            r_paddr      <= '0;
            r_pwdata     <= '0;
            r_pwrite     <= 1'b1;
        end else begin
            r_pwrite <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_state      <= S_SETUP;
                        r_last_grant <= w_grant;
                        r_psel       <= 1'b1;
                        r_paddr      <= ADDR_BASE + ADDR_W'(w_grant) * ADDR_STRIDE;
                        r_pwdata     <= DATA_W'(r_cnt[w_grant]);
                    end
                end
                S_SETUP: begin
                    r_state   <= S_ACCESS;
                    r_penable <= 1'b1;
                end
                S_ACCESS: begin
                    if (apb_pready_i) begin
                        r_state   <= S_IDLE;
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                end
            endcase
        end
    end

    assign apb_psel_o    = r_psel;
    assign apb_penable_o = r_penable;
    assign apb_paddr_o   = r_paddr;
    assign apb_pwrite_o  = r_pwrite;
    assign apb_pwdata_o  = r_pwdata;

endmodule
